// File: rtl/trg_ack_sequencer.sv
// rtl/trg_ack_sequencer.sv - per-channel TRG pulse / ACK wait handshake engine
// Each channel drives a fixed-width trigger, then waits for an ACK rising edge or a timeout.
module trg_ack_sequencer #(
    parameter int N_CH    = 12,
    parameter int PULSE_W = 8,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 50000
) (
    input  logic            BOARD_CLOCK,
    input  logic            RST,
    input  logic [N_CH-1:0] START_I,
    input  logic            ABORT_I,
    input  logic [N_CH-1:0] CLR_I,
    input  logic [N_CH-1:0] ACK_I,
    output logic [N_CH-1:0] TRG_O,
    output logic [N_CH-1:0] BUSY_O,
    output logic [N_CH-1:0] DONE_O,
    output logic [N_CH-1:0] TMO_O,
    output logic [N_CH-1:0] ACK_SYNC_O
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0]       PULSE_LAST = 8'(PULSE_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TMO_CYC - 1);

    logic [N_CH-1:0] ack_meta;
    logic [N_CH-1:0] ack_sync_d;
    logic [N_CH-1:0] ack_rise;

    // Two-flop synchronizer for the asynchronous pins, plus one delay stage for edge detection.
    always_ff @(posedge BOARD_CLOCK or negedge RST) begin
        if (!RST) begin
            ack_meta   <= '0;
            ACK_SYNC_O <= '0;
            ack_sync_d <= '0;
        end else begin
            ack_meta   <= ACK_I;
            ACK_SYNC_O <= ack_meta;
            ack_sync_d <= ACK_SYNC_O;
        end
    end

    assign ack_rise = ACK_SYNC_O & ~ack_sync_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [7:0]       pcnt_q, pcnt_d;
        logic [TMO_W-1:0] tcnt_q, tcnt_d;
        logic             seen_q, seen_d;
        logic             trg_q, trg_d;
        logic             done_q, done_d;
        logic             tmo_q, tmo_d;
        logic [TMO_W-1:0] tcnt_inc;

        always_ff @(posedge BOARD_CLOCK or negedge RST) begin
            if (!RST) begin
                state_q <= ST_IDLE;
                pcnt_q  <= '0;
                tcnt_q  <= '0;
                seen_q  <= 1'b0;
                trg_q   <= 1'b0;
                done_q  <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                pcnt_q  <= pcnt_d;
                tcnt_q  <= tcnt_d;
                seen_q  <= seen_d;
                trg_q   <= trg_d;
                done_q  <= done_d;
                tmo_q   <= tmo_d;
            end
        end

        // The timeout counter runs from PULSE entry and saturates rather than wrapping.
        assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TMO_W'(1);

        always_comb begin
            state_d = state_q;
            pcnt_d  = pcnt_q;
            tcnt_d  = tcnt_q;
            seen_d  = seen_q;
            trg_d   = trg_q;
            done_d  = done_q & ~CLR_I[g];
            tmo_d   = tmo_q & ~CLR_I[g];

            case (state_q)
                ST_IDLE: begin
                    if (START_I[g]) begin
                        state_d = ST_PULSE;
                        trg_d   = 1'b1;
                        pcnt_d  = '0;
                        tcnt_d  = '0;
                        seen_d  = 1'b0;
                        done_d  = 1'b0;
                        tmo_d   = 1'b0;
                    end
                end
                ST_PULSE: begin
                    tcnt_d = tcnt_inc;
                    if (ack_rise[g]) begin
                        seen_d = 1'b1;
                    end
                    if (pcnt_q == PULSE_LAST) begin
                        trg_d = 1'b0;
                        // A rise on the very last pulse cycle still counts as an early ACK.
                        if (seen_q || ack_rise[g]) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (pcnt_q != 8'hFF) begin
                        pcnt_d = pcnt_q + 8'd1;
                    end
                end
                ST_WAIT: begin
                    trg_d = 1'b0;
                    if (ack_rise[g]) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (tcnt_q == TMO_LAST) begin
                        state_d = ST_IDLE;
                        tmo_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    trg_d   = 1'b0;
                end
            endcase

            // Abort wins over everything and never sets status.
            if (ABORT_I) begin
                state_d = ST_IDLE;
                trg_d   = 1'b0;
                done_d  = done_q & ~CLR_I[g];
                tmo_d   = tmo_q & ~CLR_I[g];
            end
        end

        assign TRG_O[g]  = trg_q;
        assign BUSY_O[g] = (state_q != ST_IDLE);
        assign DONE_O[g] = done_q;
        assign TMO_O[g]  = tmo_q;
    end

endmodule

// File: tb/tb_trg_ack_sequencer.sv
// tb/tb_trg_ack_sequencer.sv - randomized and directed bench for trg_ack_sequencer
module tb_trg_ack_sequencer;

    localparam int N   = 12;
    localparam int PW  = 8;
    localparam int TW  = 16;
    localparam int TMO = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] start, clr, ack;
    logic         abort;
    logic [N-1:0] trg_o, busy_o, done_o, tmo_o, sync_o;

    int n_checks = 0;
    int n_fail   = 0;

    trg_ack_sequencer #(
        .N_CH(N), .PULSE_W(PW), .TMO_W(TW), .TMO_CYC(TMO)
    ) dut (
        .BOARD_CLOCK(clk),
        .RST(rst_n),
        .START_I(start),
        .ABORT_I(abort),
        .CLR_I(clr),
        .ACK_I(ack),
        .TRG_O(trg_o),
        .BUSY_O(busy_o),
        .DONE_O(done_o),
        .TMO_O(tmo_o),
        .ACK_SYNC_O(sync_o)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, the edge index at which it started and whether it is active.
    int           m_e;
    int           m_s[N];
    bit           m_act[N];
    bit           m_seen[N];
    logic [N-1:0] m_done, m_tmo, m_trg, m_busy, m_sync;
    logic [N-1:0] ah0, ah1, ah2;

    task automatic model_reset();
        m_e = 0;
        for (int i = 0; i < N; i++) begin
            m_s[i] = 0; m_act[i] = 0; m_seen[i] = 0;
        end
        m_done = '0; m_tmo = '0; m_trg = '0; m_busy = '0; m_sync = '0;
        ah0 = '0; ah1 = '0; ah2 = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] rise;
        int k;
        rise = ah1 & ~ah2;
        m_e++;
        for (int i = 0; i < N; i++) begin
            if (clr[i]) begin m_done[i] = 0; m_tmo[i] = 0; end
            if (abort) begin
                m_act[i] = 0;
            end else if (!m_act[i]) begin
                if (start[i]) begin
                    m_act[i] = 1; m_s[i] = m_e; m_seen[i] = 0; m_done[i] = 0; m_tmo[i] = 0;
                end
            end else begin
                k = m_e - m_s[i];
                if (k <= PW) begin
                    if (rise[i]) m_seen[i] = 1;
                    if (k == PW && m_seen[i]) begin m_act[i] = 0; m_done[i] = 1; end
                end else if (rise[i]) begin
                    m_act[i] = 0; m_done[i] = 1;
                end else if (k == TMO) begin
                    m_act[i] = 0; m_tmo[i] = 1;
                end
            end
            m_busy[i] = m_act[i];
            m_trg[i]  = m_act[i] && ((m_e - m_s[i]) < PW);
        end
        ah2 = ah1; ah1 = ah0; ah0 = ack;
        m_sync = ah1;
    endtask

    function automatic logic [5*N-1:0] exp_vec();
        return {m_trg, m_busy, m_done, m_tmo, m_sync};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        start = '0; abort = 1'b0; clr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = '0; abort = 1'b0; clr = '0; ack = '1;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {trg_o, busy_o, done_o, tmo_o, sync_o});
        end
        ack = '0;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic_ack();
        int trg_cycles = 0;
        int done_lat = -1;
        logic prev_busy = 1'b0;
        start[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 20) ack[0] = 1'b1;
            tick();
            n_checks++;
            if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_model c=%0d: got %h want %h", c, {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
            end
            if (trg_o[0]) trg_cycles++;
            if (c >= 20 && done_o[0] && done_lat < 0) begin
                done_lat = c - 20 + 1;
                n_checks++;
                if (!(prev_busy === 1'b1 && busy_o[0] === 1'b0)) begin
                    n_fail++;
                    $display("FAIL basic_busy_drop: prev %b now %b want 1 then 0", prev_busy, busy_o[0]);
                end
            end
            prev_busy = busy_o[0];
        end
        n_checks++;
        if (trg_cycles != PW) begin
            n_fail++; $display("FAIL basic_trg_width: got %0d want %0d", trg_cycles, PW);
        end
        n_checks++;
        if (done_lat < 1 || done_lat > 4) begin
            n_fail++; $display("FAIL basic_done_latency: got %0d want 1..4", done_lat);
        end
        n_checks++;
        if (done_o !== 12'h001 || tmo_o !== 12'h000) begin
            n_fail++; $display("FAIL basic_status: done %h tmo %h want 001 000", done_o, tmo_o);
        end
        ack = '0;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        start[5] = 1'b1;
        tick();
        n_checks++;
        if (trg_o[5] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_trg_rise: got %b want 1", trg_o[5]);
        end
        while (cnt < 1100) begin
            tick();
            cnt++;
            n_checks++;
            if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_model cnt=%0d: got %h want %h", cnt, {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
            end
            if (tmo_o[5]) break;
        end
        n_checks++;
        if (cnt != TMO) begin
            n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", cnt, TMO);
        end
        n_checks++;
        if (done_o[5] !== 1'b0 || busy_o[5] !== 1'b0 || tmo_o[5] !== 1'b1) begin
            n_fail++; $display("FAIL timeout_status: done %b busy %b tmo %b want 0 0 1", done_o[5], busy_o[5], tmo_o[5]);
        end
    endtask

    task automatic test_early_stale();
        int r;
        int done3_at = -1;
        int c = 0;
        r = int'($urandom_range(1, 5));
        ack[4] = 1'b1;
        repeat (4) tick();
        start = 12'h018;
        tick();
        while (c < 1100) begin
            c++;
            if (c == r) ack[3] = 1'b1;
            tick();
            n_checks++;
            if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
                n_fail++;
                $display("FAIL early_model c=%0d: got %h want %h", c, {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
            end
            if (done_o[3] && done3_at < 0) done3_at = c;
            if (!busy_o[4]) break;
        end
        n_checks++;
        if (done3_at != PW) begin
            n_fail++; $display("FAIL early_done_at_pulse_end: got %0d want %0d", done3_at, PW);
        end
        n_checks++;
        if (tmo_o[4] !== 1'b1 || done_o[4] !== 1'b0 || tmo_o[3] !== 1'b0) begin
            n_fail++; $display("FAIL stale_ack_timeout: tmo4 %b done4 %b tmo3 %b want 1 0 0", tmo_o[4], done_o[4], tmo_o[3]);
        end
        ack = '0;
        repeat (4) tick();
    endtask

    task automatic test_concurrent();
        int ack_at;
        int trg2 = 0;
        int c = 0;
        ack_at = int'($urandom_range(12, 40));
        start = '1;
        tick();
        if (trg_o[2]) trg2++;
        while (c < 1100) begin
            c++;
            if (c == 3) start[2] = 1'b1;
            if (c == ack_at) ack = 12'h555;
            tick();
            if (trg_o[2]) trg2++;
            n_checks++;
            if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
                n_fail++;
                $display("FAIL concurrent_model c=%0d: got %h want %h", c, {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
            end
            if (busy_o == '0) break;
        end
        n_checks++;
        if (done_o !== 12'h555 || tmo_o !== 12'hAAA) begin
            n_fail++; $display("FAIL concurrent_status: done %h tmo %h want 555 aaa", done_o, tmo_o);
        end
        n_checks++;
        if (trg2 != PW) begin
            n_fail++; $display("FAIL retrigger_ignored: ch2 trg cycles %0d want %0d", trg2, PW);
        end
        ack = '0;
        repeat (4) tick();
    endtask

    task automatic test_abort_clear();
        logic [N-1:0] sv_done, sv_tmo;
        start[1] = 1'b1;
        repeat (3) tick();
        sv_done = done_o; sv_tmo = tmo_o;
        abort = 1'b1; start[7] = 1'b1;
        tick();
        n_checks++;
        if (trg_o !== '0 || busy_o !== '0 || done_o !== sv_done || tmo_o !== sv_tmo) begin
            n_fail++;
            $display("FAIL abort_effect: trg %h busy %h done %h tmo %h want 0 0 %h %h", trg_o, busy_o, done_o, tmo_o, sv_done, sv_tmo);
        end
        repeat (3) tick();
        n_checks++;
        if (busy_o[7] !== 1'b0 || trg_o[7] !== 1'b0) begin
            n_fail++; $display("FAIL abort_blocks_start: busy7 %b trg7 %b want 0 0", busy_o[7], trg_o[7]);
        end
        start[0] = 1'b1;
        repeat (12) tick();
        ack[0] = 1'b1;
        tick();
        tick();
        clr[0] = 1'b1;
        tick();
        n_checks++;
        if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL clear_vs_set: done0 %b busy0 %b want 1 0", done_o[0], busy_o[0]);
        end
        clr = 12'h009;
        tick();
        n_checks++;
        if (done_o[0] !== 1'b0 || tmo_o[3] !== 1'b0 || {trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_plain: got %h want %h", {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
        end
        ack = '0;
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        int trg6 = 0;
        int c = 0;
        ack[9] = 1'b1;
        start[6] = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (busy_o[6] !== 1'b1 || trg_o[6] !== 1'b0 || {trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_pre_wait: got %h want %h", {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h want 0", {trg_o, busy_o, done_o, tmo_o, sync_o});
        end
        @(negedge clk);
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        start[6] = 1'b1;
        while (c < 60) begin
            c++;
            if (c == 14) ack[6] = 1'b1;
            tick();
            if (trg_o[6]) trg6++;
            n_checks++;
            if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
                n_fail++;
                $display("FAIL async_restart_model c=%0d: got %h want %h", c, {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
            end
            if (c > 1 && !busy_o[6]) break;
        end
        n_checks++;
        if (done_o[6] !== 1'b1 || tmo_o[6] !== 1'b0 || trg6 != PW) begin
            n_fail++; $display("FAIL async_restart: done6 %b tmo6 %b trg %0d want 1 0 %0d", done_o[6], tmo_o[6], trg6, PW);
        end
        ack = '0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 63) == 0) start[i] = 1'b1;
                if ($urandom_range(0, 31) == 0) clr[i] = 1'b1;
                if ($urandom_range(0, 39) == 0) ack[i] = ~ack[i];
            end
            if ($urandom_range(0, 499) == 0) abort = 1'b1;
            tick();
            n_checks++;
            if ({trg_o, busy_o, done_o, tmo_o, sync_o} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %h want %h", c, {trg_o, busy_o, done_o, tmo_o, sync_o}, exp_vec());
            end
        end
        ack = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_ack();
        test_timeout();
        test_early_stale();
        test_concurrent();
        test_abort_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trg_ack_sequencer.md
Name: trg_ack_sequencer

Overview:
Per-channel trigger/acknowledge handshake engine between the Wishbone register slave and the TRG/ACK board pins. Host writes a channel start mask. The block drives a fixed-width TRG pulse on each requested channel, waits for that channel's ACK rising edge, and stops waiting after a timeout. Sticky DONE and TIMEOUT status per channel is read back by the register slave. All logic runs on BOARD_CLOCK; ACK inputs are asynchronous board signals.

Parameters:
N_CH, 12, number of trigger/ack channels
PULSE_W, 8, TRG high time in BOARD_CLOCK cycles (1..255)
TMO_W, 16, width of timeout counter
TMO_CYC, 50000, cycles from TRG assertion to timeout (must be > PULSE_W, < 2^TMO_W)

Ports:
BOARD_CLOCK  in  1  system clock
RST  in  1  reset, asynchronous assert, active-low
START_I  in  N_CH  one-cycle start strobe per channel
ABORT_I  in  1  one-cycle strobe; cancels all channels
CLR_I  in  N_CH  one-cycle strobe; clears the channel's sticky DONE/TMO
ACK_I  in  N_CH  asynchronous ACK bits from pins
TRG_O  out  N_CH  registered trigger bits to pins
BUSY_O  out  N_CH  channel in PULSE or WAIT state
DONE_O  out  N_CH  sticky: ACK received
TMO_O  out  N_CH  sticky: timeout expired without ACK
ACK_SYNC_O  out  N_CH  synchronized ACK level, for register readback

Behaviour:
- Reset: RST low asynchronously clears the following to 0: all FSMs (IDLE), TRG_O, BUSY_O, DONE_O, TMO_O, ACK_SYNC_O, sync flops, counters.
- ACK_I passes through a 2-flop synchronizer; ACK_SYNC_O is the second stage. The edge detector registers ACK_SYNC_O; a rising edge is ack_rise = sync & ~sync_d.
- Each channel has an independent FSM with states IDLE, PULSE, WAIT, plus shared pulse counter logic per channel.
- IDLE: START_I[i]=1 -> PULSE. On the next edge, TRG_O[i]=1, BUSY_O[i]=1, clear DONE_O[i] and TMO_O[i], pulse count=0, timeout count=0, ack_seen=0. START_I[i] while BUSY is ignored; there is no retrigger and no queueing.
- PULSE: TRG_O[i] high for exactly PULSE_W cycles. Any ack_rise latches ack_seen. At the end of the pulse:
  - ack_seen=1 -> IDLE with DONE_O[i] set.
  - otherwise -> WAIT.
- WAIT: TRG_O[i]=0.
  - ack_rise -> IDLE, set DONE_O[i].
  - Timeout count reaching TMO_CYC-1 (counted from PULSE entry) -> IDLE, set TMO_O[i].
  - If ack_rise and timeout occur in the same cycle, DONE wins and TMO stays 0.
- An ACK already high at START does not count; only a rising edge after PULSE entry counts.
- BUSY_O[i]=1 exactly while in PULSE or WAIT.
- ABORT_I: on the next edge every channel returns to IDLE with TRG_O=0 and BUSY_O=0. DONE/TMO keep their prior values; abort sets neither. ABORT_I has priority over START_I in the same cycle.
- CLR_I[i] clears DONE_O[i]/TMO_O[i]. If CLR_I and a set happen in the same cycle, the set wins.
- Timing: START_I at edge n gives TRG_O high at n+1 through n+PULSE_W. An ACK_I rise is seen as ack_rise about 3 edges later. DONE_O is set one edge after ack_rise.
- Counters saturate and never wrap. Widths: pulse counter 8 bits; timeout counter TMO_W bits.
- Reset asserted mid-handshake forces TRG_O low immediately, asynchronously.

Test Plan:
- Basic ack on ch0, with PULSE_W=8 and TMO_CYC=1000:
  - Stimulus: START_I=0x001; ACK_I[0] rises 20 cycles later.
  - Required: TRG_O[0] high exactly 8 cycles; DONE_O=0x001 within 4 cycles of the ACK rise; TMO_O=0; BUSY_O[0] drops with DONE.
- Timeout on ch5:
  - Stimulus: START_I=0x020; ACK never rises.
  - Required: TMO_O[5]=1 exactly 1000 cycles after TRG_O[5] rises; DONE_O[5]=0; BUSY_O[5]=0.
- Early ack and stale-high ack:
  - Stimulus: ch3 ACK rises during the pulse; ch4 ACK is held high before START and stays high.
  - Required: ch3 gets DONE at pulse end. ch4 times out, because no rising edge occurred.
- Concurrent channels and ignored retrigger:
  - Stimulus: START_I=0xFFF; then START_I[2] again during BUSY; then ACKs on even channels only.
  - Required: DONE_O=0x555, TMO_O=0xAAA; ch2 produces only one 8-cycle TRG pulse.
- Abort and clear:
  - Stimulus: ABORT_I mid-pulse on ch1, in the same cycle as START_I[7].
  - Required: TRG_O=0 and BUSY_O=0 next cycle; ch7 not started; DONE/TMO unchanged.
  - Stimulus: CLR_I=0x001 in the same cycle as ch0 DONE being set.
  - Required: DONE_O[0] stays 1.
- Async reset:
  - Stimulus: drop RST mid-WAIT on ch6.
  - Required: all outputs 0 before the next clock edge; after release, ch6 is IDLE and restarts cleanly on START.
